// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 single-bit mux path; grant/select are registered.
// Latency 1 cycle req->gnt; a grant ends on owner req drop or HOLD_MAX expiry, re-arbitrating in the same edge.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [CW-1:0]   hold_cnt;

  logic            rel_now;
  logic [1:0]      search_ptr;
  logic            win_found;
  logic [1:0]      win_idx;

  // First set bit scanning ptr, ptr+1, ptr+2, ptr+3; scanned backwards so the nearest wins.
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = search_ptr + 2'(k);
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    rel_now    = (state == GRANT) && (!req[sel] || (hold_cnt == CW'(HOLD_MAX)));
    // After a release the owner is searched last, so the scan starts just past it.
    search_ptr = (state == GRANT) ? sel + 2'd1 : ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      valid    <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << win_idx;
            sel      <= win_idx;
            valid    <= 1'b1;
            hold_cnt <= CW'(1);
          end
        end
        GRANT: begin
          if (!rel_now) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            ptr <= sel + 2'd1;
            if (win_found) begin
              gnt      <= 4'b0001 << win_idx;
              sel      <= win_idx;
              hold_cnt <= CW'(1);
            end else begin
              // sel keeps the last owner so the mux path stays put while idle.
              state    <= IDLE;
              gnt      <= 4'b0000;
              valid    <= 1'b0;
              hold_cnt <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus hand sequences for reset, rotation, expiry and HOLD_MAX=1.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req8 = 4'b0000;
  logic [3:0] req1 = 4'b0000;
  logic [3:0] gnt8, gnt1;
  logic [1:0] sel8, sel1;
  logic       valid8, valid1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .gnt(gnt8), .sel(sel8), .valid(valid8)
  );

  mux4_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .sel(sel1), .valid(valid1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req8 = 4'b0000;
    req1 = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    chk("onehot0_gnt8", {7'b0, $onehot0(gnt8)}, 8'd1);
    chk("valid_or8", {7'b0, valid8}, {7'b0, |gnt8});
    if (valid8) chk("gnt_sel8", {4'b0, gnt8}, {4'b0, 4'b0001 << sel8});
    chk("onehot0_gnt1", {7'b0, $onehot0(gnt1)}, 8'd1);
    chk("valid_or1", {7'b0, valid1}, {7'b0, |gnt1});
    if (valid1) chk("gnt_sel1", {4'b0, gnt1}, {4'b0, 4'b0001 << sel1});
  end

  initial begin
    logic [3:0] eg;
    int         owner;

    // Owner 2 holds (others ignored), releases; sel holds in IDLE; ptr=3 resolves 0011 to 0.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0100, 2'b10, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0};
    tbl[7]  = '{1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0};
    // req=1010 from reset: 1 first, then 3, then ptr=0 makes 0101 pick 0.
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0};
    tbl[10] = '{1'b0, 4'b1010, 4'b0010, 2'b01, 1'b1};
    tbl[11] = '{1'b0, 4'b1010, 4'b0010, 2'b01, 1'b1};
    tbl[12] = '{1'b0, 4'b1000, 4'b1000, 2'b11, 1'b1};
    tbl[13] = '{1'b0, 4'b1000, 4'b1000, 2'b11, 1'b1};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 2'b11, 1'b0};
    tbl[15] = '{1'b0, 4'b0101, 4'b0001, 2'b00, 1'b1};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0};

    do_reset();
    chk("reset_gnt", {4'b0, gnt8}, 8'd0);
    chk("reset_sel", {6'b0, sel8}, 8'd0);
    chk("reset_valid", {7'b0, valid8}, 8'd0);

    for (int i = 0; i < 17; i++) begin
      rst  = tbl[i].rst;
      req8 = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_gnt", i), {4'b0, gnt8}, {4'b0, tbl[i].gnt});
      chk($sformatf("tbl%0d_sel", i), {6'b0, sel8}, {6'b0, tbl[i].sel});
      chk($sformatf("tbl%0d_valid", i), {7'b0, valid8}, {7'b0, tbl[i].valid});
    end

    // Asynchronous reset between edges, mid-grant.
    do_reset();
    req8 = 4'b0010;
    @(posedge clk);
    #1;
    chk("pre_arst_gnt", {4'b0, gnt8}, 8'b0000_0010);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", {4'b0, gnt8}, 8'd0);
    chk("arst_sel", {6'b0, sel8}, 8'd0);
    chk("arst_valid", {7'b0, valid8}, 8'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req8 = 4'b0100;
    @(posedge clk);
    #1;
    chk("post_arst_gnt", {4'b0, gnt8}, 8'b0000_0100);
    chk("post_arst_sel", {6'b0, sel8}, 8'b0000_0010);

    // All four requesting: 0,1,2,3,0, eight cycles each, no gaps.
    do_reset();
    req8 = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      owner = (c / 8) % 4;
      eg    = 4'b0001 << owner;
      chk($sformatf("rot%0d_gnt", c), {4'b0, gnt8}, {4'b0, eg});
      chk($sformatf("rot%0d_valid", c), {7'b0, valid8}, 8'd1);
    end

    // Lone requester 0 re-granted on expiry; req[2] raised later wins at the next expiry.
    do_reset();
    req8 = 4'b0001;
    for (int c = 0; c < 26; c++) begin
      if (c == 20) req8 = 4'b0101;
      @(posedge clk);
      #1;
      eg = (c < 24) ? 4'b0001 : 4'b0100;
      chk($sformatf("exp%0d_gnt", c), {4'b0, gnt8}, {4'b0, eg});
      chk($sformatf("exp%0d_hold", c), 8'(dut8.hold_cnt), (c < 24) ? 8'((c % 8) + 1) : 8'(c - 23));
    end

    // HOLD_MAX=1 with two requesters alternates every cycle.
    do_reset();
    req1 = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("h1_%0d_gnt", c), {4'b0, gnt1}, (c % 2 == 0) ? 8'b0000_0001 : 8'b0000_1000);
      chk($sformatf("h1_%0d_sel", c), {6'b0, sel1}, (c % 2 == 0) ? 8'd0 : 8'd3);
    end

    req1 = 4'b0000;
    req8 = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
